// File: rtl/pipeline_remultiplier.sv
// rtl/pipeline_remultiplier.sv - pipelined shift-and-add rebuild of dividend = quotient * divisor + remainder
//
// Purpose: one pipeline stage per quotient bit, MSB first, one triple accepted
// per clock, no stall. Results leave in input order after DIVIDENDLEN clocks.
//
// Ports:
//   clock      in   single clock, all state on posedge
//   reset      in   synchronous, active-high; clears every stage
//   in_valid   in   triple on quotient/divisor/remainder sampled this edge
//   quotient   in   [DIVIDENDLEN-1:0] multiplier operand
//   divisor    in   [DIVISORLEN-1:0]  multiplicand
//   remainder  in   [DIVISORLEN-1:0]  addend
//   out_valid  out  result valid this cycle
//   product    out  [PRODLEN-1:0] full q*d+r (0 when not valid)
//   dividend   out  [DIVIDENDLEN-1:0] low bits of product
//   overflow   out  upper product bits nonzero
//   error      out  divisor == 0 or remainder >= divisor (advisory)

module pipeline_remultiplier #(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [DIVIDENDLEN-1:0]              quotient,
    input  logic [DIVISORLEN-1:0]               divisor,
    input  logic [DIVISORLEN-1:0]               remainder,
    output logic                                out_valid,
    output logic [DIVIDENDLEN+DIVISORLEN-1:0]   product,
    output logic [DIVIDENDLEN-1:0]              dividend,
    output logic                                overflow,
    output logic                                error
);

    localparam int N       = DIVIDENDLEN;
    localparam int PRODLEN = DIVIDENDLEN + DIVISORLEN;

    logic                   r_valid [N];
    logic [PRODLEN-1:0]     r_acc   [N];
    logic [N-1:0]           r_quot  [N];
    logic [DIVISORLEN-1:0]  r_div   [N];
    logic                   r_err   [N];

    // Partial product each stage adds: stage k handles quotient bit N-1-k.
    logic [PRODLEN-1:0]     w_addend [N];
    logic [PRODLEN-1:0]     w_acc0;
    logic                   w_err0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_addend[k] = '0;
        end
        if (quotient[N-1]) begin
            w_addend[0] = PRODLEN'(divisor) << (N - 1);
        end
        for (int k = 1; k < N; k++) begin
            if (r_quot[k-1][N-1-k]) begin
                w_addend[k] = PRODLEN'(r_div[k-1]) << (N - 1 - k);
            end
        end
    end

    // The remainder seeds the accumulator so no extra stage is needed for it.
    assign w_acc0 = PRODLEN'(remainder) + w_addend[0];
    assign w_err0 = (divisor == '0) | (remainder >= divisor);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                r_valid[k] <= 1'b0;
                r_acc[k]   <= '0;
                r_quot[k]  <= '0;
                r_div[k]   <= '0;
                r_err[k]   <= 1'b0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_acc[0]   <= w_acc0;
            r_quot[0]  <= quotient;
            r_div[0]   <= divisor;
            r_err[0]   <= w_err0;
            for (int k = 1; k < N; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_acc[k]   <= r_acc[k-1] + w_addend[k];
                r_quot[k]  <= r_quot[k-1];
                r_div[k]   <= r_div[k-1];
                r_err[k]   <= r_err[k-1];
            end
        end
    end

    // Outputs are gated by the last valid so idle cycles always read zero.
    logic [PRODLEN-1:0] w_prod;

    assign w_prod    = r_valid[N-1] ? r_acc[N-1] : '0;
    assign out_valid = r_valid[N-1];
    assign product   = w_prod;
    assign dividend  = w_prod[DIVIDENDLEN-1:0];
    assign overflow  = |w_prod[PRODLEN-1:DIVIDENDLEN];
    assign error     = r_valid[N-1] & r_err[N-1];

endmodule

// File: tb/tb_pipeline_remultiplier.sv
// tb/tb_pipeline_remultiplier.sv - scoreboard bench for pipeline_remultiplier

module tb_pipeline_remultiplier;

    localparam int NQ = 16;
    localparam int ND = 8;
    localparam int NP = NQ + ND;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [NQ-1:0]   quotient = '0;
    logic [ND-1:0]   divisor = '0;
    logic [ND-1:0]   remainder = '0;
    logic            out_valid;
    logic [NP-1:0]   product;
    logic [NQ-1:0]   dividend;
    logic            overflow;
    logic            error;

    pipeline_remultiplier #(.DIVIDENDLEN(NQ), .DIVISORLEN(ND)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .product   (product),
        .dividend  (dividend),
        .overflow  (overflow),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int unsigned   cyc;
        logic [NP-1:0] prod;
        logic          err;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle either a result is due and must match,
    // or nothing is due and every output must read zero.
    always @(negedge clock) begin
        if (mon_en) begin
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out cyc=%0d product=%h required no output", cyc, product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_vec++;
                    if (e.cyc !== cyc) begin
                        n_err++;
                        $display("FAIL out_timing got cyc=%0d required cyc=%0d", cyc, e.cyc);
                    end
                    if (product !== e.prod || dividend !== e.prod[NQ-1:0] ||
                        overflow !== (|e.prod[NP-1:NQ]) || error !== e.err) begin
                        n_err++;
                        $display("FAIL result got p=%h d=%h ov=%b er=%b required p=%h d=%h ov=%b er=%b",
                                 product, dividend, overflow, error,
                                 e.prod, e.prod[NQ-1:0], |e.prod[NP-1:NQ], e.err);
                    end
                end
            end else begin
                n_vec++;
                if (product !== '0 || dividend !== '0 || overflow !== 1'b0 || error !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_zero got p=%h d=%h ov=%b er=%b required all 0",
                             product, dividend, overflow, error);
                end
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    n_err++;
                    $display("FAIL missing_out got out_valid=0 at cyc=%0d required result p=%h",
                             cyc, sb[0].prod);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit v, input logic [NQ-1:0] q, input logic [ND-1:0] d,
                         input logic [ND-1:0] r, input logic [NP-1:0] p, input logic e);
        exp_t x;
        @(negedge clock);
        in_valid  = v;
        quotient  = q;
        divisor   = d;
        remainder = r;
        if (v && !reset) begin
            x.cyc  = cyc + NQ;
            x.prod = p;
            x.err  = e;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        idle(1);
        while (sb.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    function automatic logic [NP-1:0] model(input logic [NQ-1:0] q, input logic [ND-1:0] d,
                                            input logic [ND-1:0] r);
        return NP'(q) * NP'(d) + NP'(r);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        // in_valid during reset must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; quotient = 16'hFFFF; divisor = 8'hFF; remainder = 8'h01;
        end
        n_vec++;
        if (out_valid !== 1'b0 || product !== '0 || dividend !== '0 || overflow !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got v=%b p=%h d=%h ov=%b er=%b required all 0",
                     out_valid, product, dividend, overflow, error);
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        int unsigned n0;
        issue(1'b1, 16'd12, 8'd5, 8'd3, 24'h00003F, 1'b0);
        n0 = cyc;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        while (cyc < n0 + NQ - 1) @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early got out_valid=%b required 0", out_valid);
        end
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b1 || product !== 24'h00003F || dividend !== 16'h003F ||
            overflow !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL single_result got v=%b p=%h d=%h ov=%b er=%b required 1 00003f 003f 0 0",
                     out_valid, product, dividend, overflow, error);
        end
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_late got out_valid=%b required 0", out_valid);
        end
        drain();
    endtask

    task automatic test_max();
        issue(1'b1, 16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back_illegal();
        issue(1'b1, 16'd3, 8'd0, 8'd9, 24'd9, 1'b1);
        issue(1'b1, 16'd2, 8'd7, 8'd7, 24'd21, 1'b1);
        drain();
    endtask

    task automatic test_stream();
        int sent;
        logic [NQ-1:0] q;
        logic [ND-1:0] d, r;
        sent = 0;
        while (sent < 40) begin
            q = NQ'($urandom);
            d = ND'($urandom);
            r = ND'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                issue(1'b1, q, d, r, model(q, d, r), (d == 0) || (r >= d));
                sent++;
            end else begin
                issue(1'b0, q, d, r, '0, 1'b0);
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, NQ'(i + 100), ND'(i + 3), 8'd1, model(NQ'(i + 100), ND'(i + 3), 8'd1), 1'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        // triples 6..8 are presented while reset is held
        in_valid = 1'b1; quotient = 16'd7; divisor = 8'd9; remainder = 8'd2;
        @(negedge clock);
        in_valid = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || product !== '0) begin
            n_err++;
            $display("FAIL reset_flush got v=%b p=%h required 0 0", out_valid, product);
        end
        @(negedge clock);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        idle(24);
        issue(1'b1, 16'd1, 8'd1, 8'd0, 24'd1, 1'b0);
        drain();
    endtask

    task automatic test_loopback();
        logic [NQ-1:0] dd;
        logic [ND-1:0] dv;
        for (int i = 0; i < 24; i++) begin
            dd = NQ'($urandom);
            dv = ND'($urandom_range(1, 255));
            issue(1'b1, dd / NQ'(dv), dv, ND'(dd % NQ'(dv)), NP'(dd), 1'b0);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_back_to_back_illegal();
        test_stream();
        test_reset_midflight();
        test_loopback();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
